// File: rtl/wb_pkg.sv
// Shared definitions for the write-back port arbiter: RegDst codes,
// link register address and the arbitration FSM state.
package wb_pkg;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam int RA_ADDR = 31;

  typedef enum logic {
    ALU_PRI  = 1'b0,
    SLOW_PRI = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Producer/consumer bundle for the write-back port: ALU and slow-path
// request channels plus the register-file write port and queue status.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              alu_valid;
  logic              alu_ready;
  logic [1:0]        alu_regdst;
  logic [ADDR_W-1:0] alu_rt;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              slow_valid;
  logic              slow_ready;
  logic [ADDR_W-1:0] slow_addr;
  logic [DATA_W-1:0] slow_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [1:0]        slow_pending;

  modport master (
    output alu_valid, alu_regdst, alu_rt, alu_rd, alu_data,
    output slow_valid, slow_addr, slow_data,
    input  alu_ready, slow_ready, rf_we, rf_waddr, rf_wdata, slow_pending
  );

  modport slave (
    input  alu_valid, alu_regdst, alu_rt, alu_rd, alu_data,
    input  slow_valid, slow_addr, slow_data,
    output alu_ready, slow_ready, rf_we, rf_waddr, rf_wdata, slow_pending
  );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry synchronous FIFO. No bypass: a pushed entry becomes visible at
// the head one edge later. A push while full is dropped even if a pop happens
// in the same cycle, so the caller must gate push with !full.
module wb_fifo2 #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; count moves by push minus pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= !wr_ptr;
      end
      if (pop_ok) rd_ptr <= !rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: owns the single register-file write port, gives
// the ALU fixed priority and drains the slow-path queue when the ALU is idle
// or when a queued entry has waited STARVE_LIMIT cycles.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int RA_ADDR      = wb_pkg::RA_ADDR
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_port_arbiter_if.slave bus
);

  import wb_pkg::*;

  localparam int                SW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]     LIM = SW'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] RA  = ADDR_W'(RA_ADDR);
  localparam int                QW  = ADDR_W + DATA_W;

  wb_state_e         state;
  logic [SW-1:0]     starve;
  logic [ADDR_W-1:0] alu_dest;
  logic [QW-1:0]     q_head;
  logic [1:0]        q_count;
  logic              q_full;
  logic              q_empty;
  logic              push;
  logic              pop;
  logic              sel_alu;
  logic              sel_v;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  wb_fifo2 #(.W(QW)) u_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({bus.slow_addr, bus.slow_data}),
    .dout  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  // Ready signals depend only on registered state, never on the valids.
  assign bus.alu_ready    = (state == ALU_PRI);
  assign bus.slow_ready   = !q_full;
  assign bus.slow_pending = q_count;
  assign push             = bus.slow_valid && !q_full;

  // RegDst decode; both upper codes select the link register.
  always_comb begin
    alu_dest = RA;
    case (bus.alu_regdst)
      REGDST_RT: alu_dest = bus.alu_rt;
      REGDST_RD: alu_dest = bus.alu_rd;
      default:   alu_dest = RA;
    endcase
  end

  // Pick at most one producer for this cycle's write.
  always_comb begin
    sel_alu  = (state == ALU_PRI) && bus.alu_valid;
    pop      = !q_empty && ((state == SLOW_PRI) || !bus.alu_valid);
    sel_v    = sel_alu || pop;
    sel_addr = sel_alu ? alu_dest : q_head[QW-1:DATA_W];
    sel_data = sel_alu ? bus.alu_data : q_head[DATA_W-1:0];
  end

  // Arbitration FSM with starve counter; SLOW_PRI lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ALU_PRI;
      starve <= '0;
    end else begin
      if (q_empty || pop)  starve <= '0;
      else if (starve != LIM) starve <= starve + 1'b1;
      case (state)
        ALU_PRI:  if (!q_empty && !pop && (starve == LIM - 1'b1)) state <= SLOW_PRI;
        SLOW_PRI: state <= ALU_PRI;
        default:  state <= ALU_PRI;
      endcase
    end
  end

  // Registered write port; writes to $0 are consumed but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_we <= sel_v && (sel_addr != '0);
      if (sel_v) begin
        bus.rf_waddr <= sel_addr;
        bus.rf_wdata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: RegDst decode, $0 suppression,
// starvation override, slow-path latency, push/pop at count 1, async reset.
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = !clk;

  wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_port_arbiter #(
    .DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4), .RA_ADDR(31)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, 32'(bus.rf_we), 32'(we));
    chk({tag, ".waddr"}, 32'(bus.rf_waddr), 32'(a));
    chk({tag, ".wdata"}, bus.rf_wdata, d);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.alu_valid  = 1'b0;
    bus.alu_regdst = 2'b00;
    bus.alu_rt     = '0;
    bus.alu_rd     = '0;
    bus.alu_data   = '0;
    bus.slow_valid = 1'b0;
    bus.slow_addr  = '0;
    bus.slow_data  = '0;
    #3;
    rf("rst", 1'b0, 5'd0, 32'h0);
    chk("rst.pending", 32'(bus.slow_pending), 32'd0);
    chk("rst.alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("rst.slow_ready", 32'(bus.slow_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ALU, regdst rd
    bus.alu_valid = 1'b1; bus.alu_regdst = 2'b01; bus.alu_rd = 5'd5;
    bus.alu_rt = 5'd7; bus.alu_data = 32'hA5;
    tick();
    rf("alu_rd", 1'b1, 5'd5, 32'hA5);
    // regdst 10 / 11 -> $31
    bus.alu_regdst = 2'b10; bus.alu_rt = 5'd3; bus.alu_rd = 5'd9; bus.alu_data = 32'h11;
    tick();
    rf("alu_ra10", 1'b1, 5'd31, 32'h11);
    bus.alu_regdst = 2'b11; bus.alu_data = 32'h22;
    tick();
    rf("alu_ra11", 1'b1, 5'd31, 32'h22);
    // rd = 0: consumed, no write enable
    bus.alu_regdst = 2'b01; bus.alu_rd = 5'd0; bus.alu_data = 32'h33;
    chk("zero.alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    rf("alu_zero", 1'b0, 5'd0, 32'h33);
    bus.alu_regdst = 2'b00; bus.alu_rt = 5'd3; bus.alu_data = 32'h44;
    tick();
    rf("alu_rt", 1'b1, 5'd3, 32'h44);
    bus.alu_valid = 1'b0;
    tick();
    chk("idle.we", 32'(bus.rf_we), 32'd0);

    // Starvation: ALU always valid, three slow pushes
    bus.alu_valid = 1'b1; bus.alu_regdst = 2'b00; bus.alu_rt = 5'd4; bus.alu_data = 32'h77;
    bus.slow_valid = 1'b1; bus.slow_addr = 5'd10; bus.slow_data = 32'hD1;
    tick();                                        // E1: D1 in
    chk("st.pend1", 32'(bus.slow_pending), 32'd1);
    bus.slow_addr = 5'd11; bus.slow_data = 32'hD2;
    tick();                                        // E2: D2 in
    chk("st.pend2", 32'(bus.slow_pending), 32'd2);
    chk("st.slow_ready0", 32'(bus.slow_ready), 32'd0);
    bus.slow_addr = 5'd12; bus.slow_data = 32'hD3;
    tick();                                        // E3: D3 refused
    chk("st.full_hold", 32'(bus.slow_pending), 32'd2);
    tick();                                        // E4
    chk("st.alu_ready_e4", 32'(bus.alu_ready), 32'd1);
    tick();                                        // E5: limit reached
    chk("st.alu_ready_e5", 32'(bus.alu_ready), 32'd0);
    rf("st.alu_e5", 1'b1, 5'd4, 32'h77);
    bus.alu_data = 32'h78;
    tick();                                        // E6: D1 forced out
    rf("st.d1", 1'b1, 5'd10, 32'hD1);
    chk("st.alu_ready_e6", 32'(bus.alu_ready), 32'd1);
    chk("st.pend_e6", 32'(bus.slow_pending), 32'd1);
    bus.alu_valid = 1'b0;                          // D3 still offered
    tick();                                        // E7: pop D2, push D3
    rf("st.d2", 1'b1, 5'd11, 32'hD2);
    chk("st.pend_e7", 32'(bus.slow_pending), 32'd1);
    bus.slow_valid = 1'b0;
    tick();
    rf("st.d3", 1'b1, 5'd12, 32'hD3);
    chk("st.pend_e8", 32'(bus.slow_pending), 32'd0);
    tick();
    chk("st.idle", 32'(bus.rf_we), 32'd0);

    // Slow only, ALU idle: no bypass
    bus.slow_valid = 1'b1; bus.slow_addr = 5'd7; bus.slow_data = 32'hBEEF;
    tick();
    bus.slow_valid = 1'b0;
    chk("sl.pend1", 32'(bus.slow_pending), 32'd1);
    chk("sl.nobypass", 32'(bus.rf_we), 32'd0);
    tick();
    rf("sl.write", 1'b1, 5'd7, 32'hBEEF);
    chk("sl.pend0", 32'(bus.slow_pending), 32'd0);
    tick();
    chk("sl.idle", 32'(bus.rf_we), 32'd0);

    // Push and pop together at count 1
    bus.slow_valid = 1'b1; bus.slow_addr = 5'd13; bus.slow_data = 32'hA1;
    tick();
    bus.slow_addr = 5'd14; bus.slow_data = 32'hB2;
    tick();
    rf("pp.a", 1'b1, 5'd13, 32'hA1);
    chk("pp.pend", 32'(bus.slow_pending), 32'd1);
    bus.slow_valid = 1'b0;
    tick();
    rf("pp.b", 1'b1, 5'd14, 32'hB2);
    chk("pp.pend0", 32'(bus.slow_pending), 32'd0);

    // Reset while in SLOW_PRI with two entries queued
    bus.alu_valid = 1'b1; bus.alu_data = 32'h55;
    bus.slow_valid = 1'b1; bus.slow_addr = 5'd20; bus.slow_data = 32'hE1;
    tick();
    bus.slow_addr = 5'd21; bus.slow_data = 32'hE2;
    tick();
    bus.slow_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("rr.slow_pri", 32'(bus.alu_ready), 32'd0);
    chk("rr.pend2", 32'(bus.slow_pending), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr.pend", 32'(bus.slow_pending), 32'd0);
    chk("rr.we", 32'(bus.rf_we), 32'd0);
    bus.alu_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rr.alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    chk("rr.we_after", 32'(bus.rf_we), 32'd0);
    chk("rr.pend_after", 32'(bus.slow_pending), 32'd0);
    tick();
    chk("rr.discard", 32'(bus.rf_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
